// File: rtl/tb_test_monitor.sv
// End-of-test monitor for simulation benches: watches NUM_CH PROGRESS/PASS/FAIL register sets and
// decides pass, fail, timeout or stall, then drains for a few cycles before signalling done.
module tb_test_monitor #(
  parameter int unsigned NUM_CH       = 1,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MAX_CLOCKS   = 100000,
  parameter int unsigned STALL_LIMIT  = 0,
  parameter bit          PASS_ALL     = 1'b1,
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter bit          FINISH_EN    = 1'b1
) (
  input  logic                     sim_clk,
  input  logic                     sim_rst,
  input  logic [NUM_CH*DATA_W-1:0] progress,
  input  logic [NUM_CH*DATA_W-1:0] pass,
  input  logic [NUM_CH*DATA_W-1:0] fail,
  output logic [NUM_CH-1:0]        progress_evt,
  output logic                     done,
  output logic [2:0]               status,
  output logic [3:0]               fail_ch,
  output logic [DATA_W-1:0]        fail_code,
  output logic [31:0]              cycle_cnt
);

  typedef enum logic [1:0] {StInit, StRun, StDrain, StDone} state_e;

  localparam logic [2:0] StatRun     = 3'd0;
  localparam logic [2:0] StatPass    = 3'd1;
  localparam logic [2:0] StatFail    = 3'd2;
  localparam logic [2:0] StatTimeout = 3'd3;
  localparam logic [2:0] StatStall   = 3'd4;

  state_e                     state;
  logic [NUM_CH*DATA_W-1:0]   snap;
  logic [31:0]                stall_cnt;
  logic [7:0]                 drain_cnt;

  logic [NUM_CH-1:0]          changed;
  logic [NUM_CH-1:0]          pass_nz;
  logic [NUM_CH-1:0]          fail_nz;
  logic [3:0]                 fail_idx;
  logic [DATA_W-1:0]          fail_val;
  logic                       pass_hit;
  logic                       timeout_hit;
  logic                       stall_hit;
  logic                       drain_last;
  logic [2:0]                 verdict;

  always_comb begin
    changed  = '0;
    pass_nz  = '0;
    fail_nz  = '0;
    fail_idx = '0;
    fail_val = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      changed[c] = progress[c*DATA_W +: DATA_W] != snap[c*DATA_W +: DATA_W];
      pass_nz[c] = pass[c*DATA_W +: DATA_W] != '0;
      fail_nz[c] = fail[c*DATA_W +: DATA_W] != '0;
    end
    // Walk downwards so the lowest failing channel wins.
    for (int c = int'(NUM_CH) - 1; c >= 0; c--) begin
      if (fail_nz[c]) begin
        fail_idx = 4'(c);
        fail_val = fail[c*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    pass_hit    = PASS_ALL ? (&pass_nz) : (|pass_nz);
    timeout_hit = (MAX_CLOCKS != 0) && (cycle_cnt == MAX_CLOCKS - 1);
    stall_hit   = (STALL_LIMIT != 0) && !(|changed) && (stall_cnt == STALL_LIMIT - 1);
    // A zero-length drain still spends one cycle in DRAIN, so done trails status by one cycle.
    drain_last  = (DRAIN_CYCLES == 0) || (drain_cnt == 8'(DRAIN_CYCLES - 1));
    verdict     = StatRun;
    if (|fail_nz)         verdict = StatFail;
    else if (pass_hit)    verdict = StatPass;
    else if (timeout_hit) verdict = StatTimeout;
    else if (stall_hit)   verdict = StatStall;
  end

  always_ff @(posedge sim_clk or posedge sim_rst) begin
    if (sim_rst) begin
      state        <= StInit;
      snap         <= '0;
      stall_cnt    <= '0;
      drain_cnt    <= '0;
      progress_evt <= '0;
      done         <= 1'b0;
      status       <= StatRun;
      fail_ch      <= '0;
      fail_code    <= '0;
      cycle_cnt    <= '0;
    end else begin
      progress_evt <= '0;
      case (state)
        StInit: begin
          snap  <= progress;
          state <= StRun;
        end
        StRun: begin
          progress_evt <= changed;
          snap         <= progress;
          if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + 32'd1;
          if (|changed)              stall_cnt <= '0;
          else if (stall_cnt != '1)  stall_cnt <= stall_cnt + 32'd1;
          if (verdict != StatRun) begin
            status    <= verdict;
            drain_cnt <= '0;
            state     <= StDrain;
            if (verdict == StatFail) begin
              fail_ch   <= fail_idx;
              fail_code <= fail_val;
            end
          end
        end
        StDrain: begin
          progress_evt <= changed;
          snap         <= progress;
          if (drain_last) begin
            done  <= 1'b1;
            state <= StDone;
          end else begin
            drain_cnt <= drain_cnt + 8'd1;
          end
        end
        StDone: begin
          progress_evt <= changed;
          snap         <= progress;
        end
        default: state <= StInit;
      endcase
    end
  end

`ifndef SYNTHESIS
  if (FINISH_EN) begin : g_finish
    logic [DATA_W-1:0] first_pass;

    always_comb begin
      first_pass = '0;
      for (int c = int'(NUM_CH) - 1; c >= 0; c--) begin
        if (pass_nz[c]) first_pass = pass[c*DATA_W +: DATA_W];
      end
    end

    // Reads pre-edge state, so the verdict prints on the edge that enters DONE.
    always @(posedge sim_clk) begin
      if (!sim_rst && state != StInit) begin
        for (int c = 0; c < int'(NUM_CH); c++) begin
          if (changed[c]) begin
            $display("tb_test_monitor: ch%0d progress %0h", c, progress[c*DATA_W +: DATA_W]);
          end
        end
        if (state == StDrain && drain_last) begin
          case (status)
            StatPass:    $display("tb_test_monitor: verdict pass, pass value %0h", first_pass);
            StatFail:    $display("tb_test_monitor: verdict fail, ch%0d code %0h", fail_ch,
                                  fail_code);
            StatTimeout: $display("tb_test_monitor: verdict timeout after %0d cycles", cycle_cnt);
            default:     $display("tb_test_monitor: verdict stall after %0d cycles", cycle_cnt);
          endcase
          $finish;
        end
      end
    end
  end
`endif

endmodule
